// File: rtl/amp_i2c_bus_monitor.sv
// amp_i2c_bus_monitor: passive observer of the amp configuration I2C bus.
// Decodes START/STOP, data bytes and ACK slots; keeps counters and sticky errors.
// Optional feature macro: AMP_I2C_MON_CAPTURE_EN (last four bytes capture).
module amp_i2c_bus_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [15:0] BUS_TIMEOUT = 16'd65535
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        scl,
  input  logic        sdao,
  input  logic        sdai,
  input  logic        clr_err,
  output logic        busy,
  output logic        start_det,
  output logic        stop_det,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_ack,
  output logic [3:0]  byte_idx,
  output logic [7:0]  xfer_cnt,
  output logic [7:0]  nack_cnt,
  output logic        err_nack,
  output logic        err_frame,
  output logic        err_timeout,
  output logic [31:0] last_bytes
);

  localparam int unsigned BIT_W = 4;
  localparam int unsigned TMO_W = 16;
  localparam logic [TMO_W-1:0] TMO_LAST = BUS_TIMEOUT - 16'd1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t             state, state_nxt;
  logic [SYNC_STAGES-1:0] scl_sync, sdao_sync, sdai_sync;
  logic               scl_s, sda_s, scl_d, sda_d;
  logic               start_c, stop_c, scl_rise, scl_fall;
  logic               go_start, go_stop, shift_en, byte_done, frame_set, tmo_fire;
  logic [BIT_W-1:0]   bit_cnt;
  logic               pend;
  logic [3:0]         idx_cnt;
  logic [7:0]         shreg;
  logic [TMO_W-1:0]   tmo_cnt;

  // Input synchronizers and edge-detect registers; idle-high so reset cannot fake a START
  always_ff @(posedge clk) begin
    if (!resetb) begin
      scl_sync  <= '1;
      sdao_sync <= '1;
      sdai_sync <= '1;
      scl_d     <= 1'b1;
      sda_d     <= 1'b1;
    end else begin
      scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl};
      sdao_sync <= {sdao_sync[SYNC_STAGES-2:0], sdao};
      sdai_sync <= {sdai_sync[SYNC_STAGES-2:0], sdai};
      scl_d     <= scl_s;
      sda_d     <= sda_s;
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sdao_sync[SYNC_STAGES-1] & sdai_sync[SYNC_STAGES-1];
  assign start_c  = sda_d & ~sda_s & scl_s;
  assign stop_c   = ~sda_d & sda_s & scl_s;
  assign scl_rise = ~scl_d & scl_s;
  assign scl_fall = scl_d & ~scl_s;

  // State register
  always_ff @(posedge clk) begin
    if (!resetb) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state and per-cycle event strobes. A START/STOP always lands in an scl-high
  // phase whose rising edge already counted a bit (pend); that bit is not a framing loss.
  always_comb begin
    state_nxt = state;
    go_start  = 1'b0;
    go_stop   = 1'b0;
    shift_en  = 1'b0;
    byte_done = 1'b0;
    frame_set = 1'b0;
    tmo_fire  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_c) begin
          state_nxt = ACTIVE;
          go_start  = 1'b1;
        end
      end
      ACTIVE: begin
        if (start_c) begin
          go_start  = 1'b1;
          frame_set = (bit_cnt != {3'b000, pend});
        end else if (stop_c) begin
          state_nxt = IDLE;
          go_stop   = 1'b1;
          frame_set = (bit_cnt != {3'b000, pend});
        end else if (scl_rise) begin
          if (bit_cnt == 4'd8) byte_done = 1'b1;
          else                 shift_en  = 1'b1;
        end else if (!scl_fall && (tmo_cnt >= TMO_LAST)) begin
          tmo_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus-idle timer: reloads on START and on every scl edge while active
  always_ff @(posedge clk) begin
    if (!resetb)                           tmo_cnt <= '0;
    else if (state_nxt != ACTIVE)          tmo_cnt <= '0;
    else if (go_start || scl_rise || scl_fall) tmo_cnt <= 16'd1;
    else                                   tmo_cnt <= tmo_cnt + 16'd1;
  end

  // Byte assembly, event pulses, counters and sticky flags; a set/increment beats clr_err
  always_ff @(posedge clk) begin
    if (!resetb) begin
      busy <= 1'b0; start_det <= 1'b0; stop_det <= 1'b0; byte_valid <= 1'b0;
      byte_data <= '0; byte_ack <= 1'b0; byte_idx <= '0;
      xfer_cnt <= '0; nack_cnt <= '0;
      err_nack <= 1'b0; err_frame <= 1'b0; err_timeout <= 1'b0;
      bit_cnt <= '0; pend <= 1'b0; idx_cnt <= '0; shreg <= '0;
    end else begin
      busy       <= (state_nxt == ACTIVE);
      start_det  <= go_start;
      stop_det   <= go_stop;
      byte_valid <= byte_done;
      if (clr_err) begin
        err_nack <= 1'b0; err_frame <= 1'b0; err_timeout <= 1'b0;
        xfer_cnt <= '0; nack_cnt <= '0;
      end
      if (go_start) begin
        bit_cnt <= '0; pend <= 1'b0; idx_cnt <= '0; byte_idx <= '0;
      end else if (go_stop) begin
        bit_cnt  <= '0;
        pend     <= 1'b0;
        xfer_cnt <= clr_err ? 8'd1 : xfer_cnt + 8'd1;
      end else if (shift_en) begin
        shreg   <= {shreg[6:0], sda_s};
        bit_cnt <= bit_cnt + 4'd1;
        pend    <= 1'b1;
      end else if (byte_done) begin
        byte_data <= shreg;
        byte_ack  <= ~sda_s;
        byte_idx  <= idx_cnt;
        if (idx_cnt != 4'd15) idx_cnt <= idx_cnt + 4'd1;
        bit_cnt   <= '0;
        if (sda_s) begin
          err_nack <= 1'b1;
          if (clr_err)                nack_cnt <= 8'd1;
          else if (nack_cnt != 8'hFF) nack_cnt <= nack_cnt + 8'd1;
        end
      end else if (scl_fall) begin
        pend <= 1'b0;
      end
      if (frame_set) err_frame   <= 1'b1;
      if (tmo_fire)  err_timeout <= 1'b1;
    end
  end

`ifdef AMP_I2C_MON_CAPTURE_EN
  // Last four bytes of the current or most recent transaction
  always_ff @(posedge clk) begin
    if (!resetb)        last_bytes <= '0;
    else if (go_start)  last_bytes <= '0;
    else if (byte_done) last_bytes <= {last_bytes[23:0], shreg};
  end
`else
  assign last_bytes = 32'h0;
`endif

endmodule

// File: tb/tb_amp_i2c_bus_monitor.sv
// Directed self-checking bench for amp_i2c_bus_monitor (BUS_TIMEOUT overridden to 100).
module tb_amp_i2c_bus_monitor;

  localparam int Q = 5;

  logic        clk = 1'b0;
  logic        resetb, scl, sdao, sdai, clr_err;
  logic        busy, start_det, stop_det, byte_valid, byte_ack;
  logic [7:0]  byte_data, xfer_cnt, nack_cnt;
  logic [3:0]  byte_idx;
  logic        err_nack, err_frame, err_timeout;
  logic [31:0] last_bytes;

  int checks = 0;
  int errors = 0;

  int n_start = 0, n_stop = 0, n_byte = 0;
  logic [7:0] rec_data [0:511];
  logic       rec_ack  [0:511];
  logic [3:0] rec_idx  [0:511];

  always #5 clk = ~clk;

  amp_i2c_bus_monitor #(.SYNC_STAGES(2), .BUS_TIMEOUT(16'd100)) dut (
    .clk(clk), .resetb(resetb), .scl(scl), .sdao(sdao), .sdai(sdai),
    .clr_err(clr_err), .busy(busy), .start_det(start_det), .stop_det(stop_det),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ack(byte_ack),
    .byte_idx(byte_idx), .xfer_cnt(xfer_cnt), .nack_cnt(nack_cnt),
    .err_nack(err_nack), .err_frame(err_frame), .err_timeout(err_timeout),
    .last_bytes(last_bytes)
  );

  // Pulse monitor: counts event pulses and logs each completed byte
  always @(negedge clk) begin
    if (start_det === 1'b1) n_start++;
    if (stop_det === 1'b1) n_stop++;
    if (byte_valid === 1'b1) begin
      if (n_byte < 512) begin
        rec_data[n_byte] = byte_data;
        rec_ack[n_byte]  = byte_ack;
        rec_idx[n_byte]  = byte_idx;
      end
      n_byte++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_lb(input logic [31:0] v);
`ifdef AMP_I2C_MON_CAPTURE_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_t(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic i2c_start;
    scl = 1'b1; sdao = 1'b1; sdai = 1'b1; wait_t(Q);
    sdao = 1'b0; wait_t(Q);
    scl = 1'b0; wait_t(Q);
  endtask

  task automatic i2c_rstart;
    sdao = 1'b1; sdai = 1'b1; wait_t(Q);
    scl = 1'b1; wait_t(Q);
    sdao = 1'b0; wait_t(Q);
    scl = 1'b0; wait_t(Q);
  endtask

  task automatic i2c_stop;
    sdao = 1'b0; sdai = 1'b1; wait_t(Q);
    scl = 1'b1; wait_t(Q);
    sdao = 1'b1; wait_t(Q);
  endtask

  // One bit cell; with clr set, clr_err is timed to hit the same edge as this bit's pulse
  task automatic send_bit(input logic bo, input logic bi, input logic clr);
    sdao = bo; sdai = bi; wait_t(Q);
    scl = 1'b1;
    if (clr) begin
      tick(); tick();
      clr_err = 1'b1; tick();
      clr_err = 1'b0; wait_t(Q - 3);
    end else begin
      wait_t(Q);
    end
    scl = 1'b0; wait_t(Q);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic ack, input logic clr);
    for (int i = 7; i >= 0; i--) send_bit(d[i], 1'b1, 1'b0);
    send_bit(1'b1, ~ack, clr);
  endtask

  task automatic pulse_clr;
    clr_err = 1'b1; tick();
    clr_err = 1'b0; tick();
  endtask

  int s0, p0, b0;

  initial begin
    resetb = 1'b0; scl = 1'b1; sdao = 1'b1; sdai = 1'b1; clr_err = 1'b0;

    // Reset / idle
    wait_t(4);
    check("rst_busy", busy, 0);
    check("rst_byte_data", byte_data, 0);
    check("rst_last_bytes", last_bytes, 0);
    resetb = 1'b1;
    wait_t(6);
    check("idle_busy", busy, 0);
    check("idle_pulses", n_start + n_stop + n_byte, 0);
    check("idle_cnts", {xfer_cnt, nack_cnt}, 0);
    check("idle_errs", {err_nack, err_frame, err_timeout}, 0);

    // Three-byte ACKed write
    s0 = n_start; p0 = n_stop; b0 = n_byte;
    i2c_start();
    check("w3_busy", busy, 1);
    send_byte(8'h40, 1'b1, 1'b0);
    send_byte(8'h40, 1'b1, 1'b0);
    send_byte(8'h18, 1'b1, 1'b0);
    i2c_stop();
    check("w3_nstart", n_start - s0, 1);
    check("w3_nstop", n_stop - p0, 1);
    check("w3_nbyte", n_byte - b0, 3);
    check("w3_b0", {rec_data[b0], rec_ack[b0], rec_idx[b0]}, {8'h40, 1'b1, 4'd0});
    check("w3_b1", {rec_data[b0+1], rec_ack[b0+1], rec_idx[b0+1]}, {8'h40, 1'b1, 4'd1});
    check("w3_b2", {rec_data[b0+2], rec_ack[b0+2], rec_idx[b0+2]}, {8'h18, 1'b1, 4'd2});
    check("w3_xfer", xfer_cnt, 1);
    check("w3_nack", nack_cnt, 0);
    check("w3_errs", {err_nack, err_frame, err_timeout}, 0);
    check("w3_busy_end", busy, 0);
    check("w3_last_bytes", last_bytes, exp_lb(32'h00404018));

    // Address NACK, then clear
    b0 = n_byte;
    i2c_start();
    send_byte(8'h40, 1'b0, 1'b0);
    i2c_stop();
    check("nk_ack", {rec_data[b0], rec_ack[b0], rec_idx[b0]}, {8'h40, 1'b0, 4'd0});
    check("nk_cnt", nack_cnt, 1);
    check("nk_err", err_nack, 1);
    check("nk_xfer", xfer_cnt, 2);
    check("nk_last_bytes", last_bytes, exp_lb(32'h00000040));
    pulse_clr();
    check("nk_clr", {xfer_cnt, nack_cnt, 5'(0), err_nack, err_frame, err_timeout}, 0);

    // Stuck clock: timeout exactly 100 clk after the last synced scl edge
    p0 = n_stop;
    i2c_start();
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0);
    sdao = 1'b1; wait_t(Q);
    scl = 1'b1; wait_t(Q);
    scl = 1'b0;
    wait_t(101);
    check("to_early", {err_timeout, busy}, 2'b01);
    tick();
    check("to_fire", {err_timeout, busy}, 2'b10);
    check("to_nostop", n_stop - p0, 0);
    check("to_other_errs", {err_nack, err_frame, xfer_cnt}, 0);
    sdao = 1'b1; wait_t(Q);
    scl = 1'b1; wait_t(Q);
    pulse_clr();

    // Frame error: STOP after 5 bits
    b0 = n_byte; p0 = n_stop;
    i2c_start();
    for (int i = 0; i < 5; i++) send_bit(1'(i & 1), 1'b1, 1'b0);
    i2c_stop();
    check("fr_stop_err", err_frame, 1);
    check("fr_stop_nobyte", n_byte - b0, 0);
    check("fr_stop_xfer", xfer_cnt, 1);
    check("fr_stop_pulse", n_stop - p0, 1);
    check("fr_stop_busy", busy, 0);
    pulse_clr();

    // Frame error: repeated START after 3 bits of the 2nd byte
    b0 = n_byte; s0 = n_start;
    i2c_start();
    send_byte(8'hA5, 1'b1, 1'b0);
    check("fr_rs_clean", err_frame, 0);
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    i2c_rstart();
    check("fr_rs_err", err_frame, 1);
    send_byte(8'h3C, 1'b1, 1'b0);
    i2c_stop();
    check("fr_rs_nstart", n_start - s0, 2);
    check("fr_rs_nbyte", n_byte - b0, 2);
    check("fr_rs_first", {rec_data[b0], rec_idx[b0]}, {8'hA5, 4'd0});
    check("fr_rs_restart", {rec_data[b0+1], rec_ack[b0+1], rec_idx[b0+1]}, {8'h3C, 1'b1, 4'd0});
    check("fr_rs_last_bytes", last_bytes, exp_lb(32'h0000003C));
    pulse_clr();

    // Saturation: 256 NACKed bytes in one transaction
    b0 = n_byte;
    i2c_start();
    for (int i = 0; i < 256; i++) send_byte(8'(i), 1'b0, 1'b0);
    check("sat_nack", nack_cnt, 8'd255);
    check("sat_nbyte", n_byte - b0, 256);
    check("sat_idx", byte_idx, 4'd15);
    check("sat_first", {rec_data[b0], rec_ack[b0], rec_idx[b0]}, {8'h00, 1'b0, 4'd0});
    check("sat_b20", {rec_data[b0+20], rec_idx[b0+20]}, {8'h14, 4'd15});

    // Priority: clr_err coincident with a NACK byte_valid
    send_byte(8'h5A, 1'b0, 1'b1);
    check("pri_err_nack", err_nack, 1);
    check("pri_nack_cnt", nack_cnt, 8'd1);
    check("pri_byte", {rec_data[b0+256], rec_ack[b0+256]}, {8'h5A, 1'b0});
    i2c_stop();
    check("pri_xfer", xfer_cnt, 1);
    check("pri_last_bytes", last_bytes, exp_lb(32'hFDFEFF5A));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/amp_i2c_bus_monitor.md
# amp_i2c_bus_monitor

Passive observer of the amplifier configuration I2C bus. It sits directly downstream of the amp I2C master and taps the master's `scl`/`sdao` outputs plus the returned line `sdai`. It decodes START/STOP conditions, data bytes and ACK slots, and exposes per-byte events, transaction counters and sticky error flags. Firmware reads these through the register bank to confirm that the amp boot sequence was accepted.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth on `scl`, `sdao` and `sdai` (≥2).
- `BUS_TIMEOUT`, default 16'd65535: clk cycles without an `scl` edge while busy before a timeout error.

Ports:
- `clk` in 1: system clock. Runs faster than the bus: at least 4 clk per `scl` phase.
- `resetb` in 1: reset, synchronous, active-low.
- `scl` in 1: SCL as driven by the master.
- `sdao` in 1: SDA as driven by the master.
- `sdai` in 1: SDA as seen on the pad (slave drive included).
- `clr_err` in 1: one-cycle pulse; clears sticky errors and all counters.
- `busy` out 1: high between START and STOP or abort.
- `start_det` out 1: one-cycle pulse on START or repeated START.
- `stop_det` out 1: one-cycle pulse on STOP.
- `byte_valid` out 1: one-cycle pulse when a byte plus its ACK bit completes.
- `byte_data` out 8: last completed byte, MSB first on wire.
- `byte_ack` out 1: 1 = ACK (line low in the 9th bit).
- `byte_idx` out 4: index of `byte_data` within the current transaction; saturates at 15.
- `xfer_cnt` out 8: STOPs seen; wraps at 255→0.
- `nack_cnt` out 8: NACKs seen; saturates at 255.
- `err_nack`, `err_frame`, `err_timeout` out 1 each: sticky error flags.
- `last_bytes` out 32: see Configuration.

## Operation
- Line value: `sda = sdao & sdai` (wired-AND), evaluated after synchronization. Synchronizer flops reset to 1, so reset cannot produce a spurious START.
- Edge detect: one extra register on synced `scl`/`sda`. An `sda` fall with `scl`=1 is START; an `sda` rise with `scl`=1 is STOP.
- States:
  - IDLE → ACTIVE on START: `bit_cnt`=0, `byte_idx`=0, pulse `start_det`.
  - ACTIVE, `scl` rise with `bit_cnt`<8: shift `sda` into the data shift register, `bit_cnt`+1.
  - ACTIVE, `scl` rise with `bit_cnt`==8:
    - `byte_data`←shift register, `byte_ack`←!`sda`, pulse `byte_valid`.
    - `bit_cnt`←0.
    - `byte_idx` advances after this byte; it is cleared by START.
    - On NACK: `nack_cnt`+1 (saturating) and set `err_nack`.
  - ACTIVE, START (repeated): treated as a new START, with no counter update. If `bit_cnt`≠0, set `err_frame`.
  - ACTIVE, STOP: → IDLE, `xfer_cnt`+1, pulse `stop_det`. If `bit_cnt`≠0, set `err_frame`, and the partial byte is discarded with no `byte_valid`.
  - ACTIVE, no `scl` edge for `BUS_TIMEOUT` cycles: set `err_timeout`, → IDLE, no `stop_det`. The timeout counter reloads on every `scl` edge.
  - IDLE: STOP is ignored; `scl` edges are ignored.
- `busy` = (state==ACTIVE).
- Simultaneous events:
  - `clr_err` in the same cycle as an error set or counter increment: the set/increment wins. The other flags and counters still clear.
  - START and `scl` edge cannot coincide by definition; if both are flagged, START has priority.

## Timing
- Latency from a pin change to the corresponding pulse (`start_det`, `stop_det`, `byte_valid`) is `SYNC_STAGES`+1 clk.
- `byte_data`, `byte_ack` and `byte_idx` are valid in the `byte_valid` cycle and held until the next byte.
- Counters and flags update in the same cycle as their event pulse.
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Synchronizers 1.
  - Timeout counter 0.
- Reset mid-transaction returns to IDLE next edge with all outputs 0. A bus already mid-byte is ignored until the next START.

## Configuration
- `AMP_I2C_MON_CAPTURE_EN`
  - Defined: `last_bytes` is a 32-bit shift register. It clears on START, and on each `byte_valid` shifts left by 8 and inserts the new byte in bits [7:0]. It therefore holds the last four bytes of the current or most recent transaction.
  - Undefined: `last_bytes` is tied to 0 and no capture flops are built.

## Test plan
1. **Reset/idle:** hold `resetb`=0 with `scl`=`sdao`=`sdai`=1, then release → all outputs 0, no pulses, `busy`=0.
2. **Three-byte ACKed write:** START, bytes 0x40, 0x40, 0x18, slave pulls `sdai` low in each 9th bit, STOP. Required response:
   - three `byte_valid` pulses with data 0x40/0x40/0x18, `byte_ack`=1, `byte_idx` 0/1/2;
   - `xfer_cnt`=1, `nack_cnt`=0, no errors;
   - `last_bytes`=0x00404018 with the macro, 0 without.
3. **Address NACK:** START, byte 0x40 with `sdai`=1 in the 9th bit, STOP → `byte_ack`=0, `nack_cnt`=1, `err_nack`=1. A following `clr_err` → flags and counters 0.
4. **Stuck clock:** `BUS_TIMEOUT`=100; START, 3 bits, then `scl` held low → `err_timeout`=1 and `busy`=0 exactly 100 clk after the last synced `scl` edge, no `stop_det`.
5. **Frame errors:** STOP after 5 bits → `err_frame`=1, no `byte_valid`, `xfer_cnt`+1. Repeated START after 3 bits of the 2nd byte → `err_frame`=1, `byte_idx` restarts at 0.
6. **Saturation and priority:** 256 NACKed bytes → `nack_cnt` holds 255. `clr_err` in the same cycle as a NACK `byte_valid` → `err_nack`=1, `nack_cnt`=1.
